// File: rtl/intersection_scheduler.sv
// Two-approach intersection phase scheduler with on-demand side road and pedestrian service.
// Optional night flashing mode is built when NIGHT_FLASH_EN is defined (adds the `night` input).
module intersection_scheduler #(
    parameter int T_GO    = 10,
    parameter int T_WARN  = 3,
    parameter int T_CLEAR = 2,
    parameter int T_PED   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       b_req,
    input  logic       ped_req,
`ifdef NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic       ped_ack,
    output logic       ped_walk,
    output logic [2:0] led_a,
    output logic [2:0] led_b,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        A_GO = 3'd0, A_WARN = 3'd1, CLEAR_A = 3'd2, B_GO = 3'd3,
        B_WARN = 3'd4, CLEAR_B = 3'd5, PED = 3'd6, FLASH = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b101, GO = 3'b110, WARN = 3'b011, OFF = 3'b111;

    state_t     state, state_nxt;
    logic [7:0] timer, timer_nxt;
    logic       b_pend, b_pend_nxt, ped_pend, ped_pend_nxt;
    logic       ped_ack_nxt, ped_walk_nxt;
    logic [2:0] led_a_nxt, led_b_nxt;
    logic       flash_on, flash_on_nxt;
    logic       expire, night_s;

    function automatic logic [7:0] dur(state_t s);
        case (s)
            A_GO, B_GO:       dur = 8'(T_GO - 1);
            A_WARN, B_WARN:   dur = 8'(T_WARN - 1);
            CLEAR_A, CLEAR_B: dur = 8'(T_CLEAR - 1);
            PED:              dur = 8'(T_PED - 1);
            default:          dur = 8'd0;
        endcase
    endfunction

`ifdef NIGHT_FLASH_EN
    assign night_s = night;
`else
    assign night_s = 1'b0;
`endif

    assign expire = tick && (timer == 8'd0);
    assign phase  = state;

    always_comb begin
        state_nxt = state;
        case (state)
            A_GO:    if (expire && (b_pend || ped_pend)) state_nxt = A_WARN;
            A_WARN:  if (expire) state_nxt = CLEAR_A;
            CLEAR_A: if (expire) begin
                         if (night_s)       state_nxt = FLASH;
                         else if (ped_pend) state_nxt = PED;
                         else if (b_pend)   state_nxt = B_GO;
                         else               state_nxt = A_GO;
                     end
            B_GO:    if (expire) state_nxt = B_WARN;
            B_WARN:  if (expire) state_nxt = CLEAR_B;
            CLEAR_B: if (expire) begin
                         if (night_s)       state_nxt = FLASH;
                         else if (ped_pend) state_nxt = PED;
                         else               state_nxt = A_GO;
                     end
            PED:     if (expire) state_nxt = A_GO;
`ifdef NIGHT_FLASH_EN
            FLASH:   if (tick && !night) state_nxt = CLEAR_A;
`endif
            default: state_nxt = A_GO;
        endcase

        // Idle A_GO parks the timer at 0 so the first tick with demand leaves.
        timer_nxt = timer;
        if (state_nxt != state)            timer_nxt = dur(state_nxt);
        else if (tick && timer != 8'd0)    timer_nxt = timer - 8'd1;

        // Clearing on entry (or while flashing) takes priority over a same-cycle request.
        b_pend_nxt   = b_pend   | (b_req   && state != B_GO);
        ped_pend_nxt = ped_pend | (ped_req && state != PED);
        if (state_nxt == B_GO || state == FLASH || state_nxt == FLASH) b_pend_nxt = 1'b0;
        if (state_nxt == PED  || state == FLASH || state_nxt == FLASH) ped_pend_nxt = 1'b0;
        ped_ack_nxt  = !ped_pend && ped_pend_nxt;
        ped_walk_nxt = (state_nxt == PED);

        // Flash phase starts dark so the first tick lights WARN.
        flash_on_nxt = 1'b0;
        if (state_nxt == FLASH && state == FLASH) flash_on_nxt = tick ? !flash_on : flash_on;

        led_a_nxt = RED;
        led_b_nxt = RED;
        case (state_nxt)
            A_GO:    led_a_nxt = GO;
            A_WARN:  led_a_nxt = WARN;
            B_GO:    led_b_nxt = GO;
            B_WARN:  led_b_nxt = WARN;
            FLASH:   begin
                         led_a_nxt = flash_on_nxt ? WARN : OFF;
                         led_b_nxt = flash_on_nxt ? WARN : OFF;
                     end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= A_GO;
            timer    <= 8'(T_GO - 1);
            b_pend   <= 1'b0;
            ped_pend <= 1'b0;
            ped_ack  <= 1'b0;
            ped_walk <= 1'b0;
            flash_on <= 1'b0;
            led_a    <= GO;
            led_b    <= RED;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            b_pend   <= b_pend_nxt;
            ped_pend <= ped_pend_nxt;
            ped_ack  <= ped_ack_nxt;
            ped_walk <= ped_walk_nxt;
            flash_on <= flash_on_nxt;
            led_a    <= led_a_nxt;
            led_b    <= led_b_nxt;
        end
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed bench for intersection_scheduler (T_GO=4, T_WARN=2, T_CLEAR=1, T_PED=3, tick every 4 clk).
`timescale 1ns/1ps
module tb_intersection_scheduler;

    logic       clk = 1'b0, rst = 1'b0, tick = 1'b0, b_req = 1'b0, ped_req = 1'b0;
`ifdef NIGHT_FLASH_EN
    logic       night = 1'b0;
`endif
    logic       ped_ack, ped_walk;
    logic [2:0] led_a, led_b, phase;
    int         n_cmp = 0, n_bad = 0, ack_cnt = 0;

    intersection_scheduler #(.T_GO(4), .T_WARN(2), .T_CLEAR(1), .T_PED(3)) dut (
        .clk(clk), .rst(rst), .tick(tick), .b_req(b_req), .ped_req(ped_req),
`ifdef NIGHT_FLASH_EN
        .night(night),
`endif
        .ped_ack(ped_ack), .ped_walk(ped_walk), .led_a(led_a), .led_b(led_b), .phase(phase)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (ped_ack === 1'b1) ack_cnt++;

    function automatic logic [2:0] exp_a(int p);
        case (p)
            0: exp_a = 3'b110;
            1: exp_a = 3'b011;
            default: exp_a = 3'b101;
        endcase
    endfunction

    function automatic logic [2:0] exp_b(int p);
        case (p)
            3: exp_b = 3'b110;
            4: exp_b = 3'b011;
            default: exp_b = 3'b101;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b0; tick = 1'b0; b_req = 1'b0; ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_b();
        b_req = 1'b1; @(posedge clk); #1 b_req = 1'b0;
    endtask

    task automatic test_reset();
        int a0;
        do_reset();
        n_cmp++; if (phase !== 3'd0 || led_a !== 3'b110 || led_b !== 3'b101 || ped_walk !== 1'b0 || ped_ack !== 1'b0) begin
            n_bad++; $display("FAIL reset_state got ph=%0d a=%b b=%b walk=%b ack=%b want 0/110/101/0/0", phase, led_a, led_b, ped_walk, ped_ack);
        end
        a0 = ack_cnt;
        for (int i = 0; i < 100; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'd0 || led_a !== 3'b110 || led_b !== 3'b101) begin
                n_bad++; $display("FAIL idle[%0d] got ph=%0d a=%b b=%b want 0/110/101", i, phase, led_a, led_b);
            end
        end
        n_cmp++; if (ack_cnt - a0 !== 0) begin
            n_bad++; $display("FAIL idle_ack got %0d pulses want 0", ack_cnt - a0);
        end
    endtask

    task automatic test_b_cycle();
        int exp[16] = '{0,0,0,1,1,2,3,3,3,3,4,4,5,0,0,0};
        do_reset();
        pulse_b();
        for (int i = 0; i < 16; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'(exp[i]) || led_a !== exp_a(exp[i]) || led_b !== exp_b(exp[i]) || ped_walk !== 1'b0) begin
                n_bad++; $display("FAIL b_cycle[%0d] got ph=%0d a=%b b=%b want ph=%0d a=%b b=%b", i+1, phase, led_a, led_b, exp[i], exp_a(exp[i]), exp_b(exp[i]));
            end
        end
    endtask

    task automatic test_ped();
        int exp[12] = '{0,0,0,1,1,2,6,6,6,0,0,0};
        do_reset();
        ped_req = 1'b1; @(posedge clk); #1 ped_req = 1'b0;
        n_cmp++; if (ped_ack !== 1'b1) begin n_bad++; $display("FAIL ped_ack_hi got %b want 1", ped_ack); end
        @(posedge clk); #1;
        n_cmp++; if (ped_ack !== 1'b0) begin n_bad++; $display("FAIL ped_ack_lo got %b want 0", ped_ack); end
        for (int i = 0; i < 12; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'(exp[i]) || led_a !== exp_a(exp[i]) || led_b !== exp_b(exp[i]) || ped_walk !== (exp[i] == 6)) begin
                n_bad++; $display("FAIL ped[%0d] got ph=%0d a=%b b=%b walk=%b want ph=%0d", i+1, phase, led_a, led_b, ped_walk, exp[i]);
            end
        end
    endtask

    task automatic test_both();
        int exp[17] = '{0,0,0,1,1,2,6,6,6,0,0,0,0,1,1,2,3};
        int a0;
        do_reset();
        a0 = ack_cnt;
        b_req = 1'b1; ped_req = 1'b1; @(posedge clk); #1 b_req = 1'b0;
        @(posedge clk); #1 ped_req = 1'b0;
        for (int i = 0; i < 17; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'(exp[i]) || led_a !== exp_a(exp[i]) || led_b !== exp_b(exp[i])) begin
                n_bad++; $display("FAIL both[%0d] got ph=%0d a=%b b=%b want ph=%0d", i+1, phase, led_a, led_b, exp[i]);
            end
        end
        n_cmp++; if (ack_cnt - a0 !== 1) begin n_bad++; $display("FAIL both_ack got %0d pulses want 1", ack_cnt - a0); end
    endtask

    task automatic test_reset_mid();
        int exp[7] = '{0,0,0,1,1,2,3};
        do_reset();
        pulse_b();
        repeat (11) tick_once();
        n_cmp++; if (phase !== 3'd4) begin n_bad++; $display("FAIL mid_pre got ph=%0d want 4", phase); end
        ped_req = 1'b1; @(posedge clk); #1 ped_req = 1'b0;
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (phase !== 3'd0 || led_a !== 3'b110 || led_b !== 3'b101 || ped_walk !== 1'b0 || ped_ack !== 1'b0) begin
            n_bad++; $display("FAIL mid_async got ph=%0d a=%b b=%b walk=%b ack=%b want 0/110/101/0/0", phase, led_a, led_b, ped_walk, ped_ack);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        pulse_b();
        for (int i = 0; i < 7; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'(exp[i])) begin
                n_bad++; $display("FAIL mid_resume[%0d] got ph=%0d want %0d", i+1, phase, exp[i]);
            end
        end
    endtask

`ifdef NIGHT_FLASH_EN
    task automatic test_flash();
        int          exp[7] = '{0,0,0,1,1,2,7};
        logic [2:0]  fl[3]  = '{3'b011, 3'b111, 3'b011};
        int          a0;
        do_reset();
        night = 1'b1;
        pulse_b();
        for (int i = 0; i < 7; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'(exp[i])) begin
                n_bad++; $display("FAIL flash_seq[%0d] got ph=%0d want %0d", i+1, phase, exp[i]);
            end
        end
        n_cmp++; if (led_a !== 3'b111 || led_b !== 3'b111 || ped_walk !== 1'b0) begin
            n_bad++; $display("FAIL flash_entry got a=%b b=%b walk=%b want 111/111/0", led_a, led_b, ped_walk);
        end
        a0 = ack_cnt;
        ped_req = 1'b1; b_req = 1'b1; @(posedge clk); #1 ped_req = 1'b0; b_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'd7 || led_a !== fl[i] || led_b !== fl[i]) begin
                n_bad++; $display("FAIL flash_toggle[%0d] got ph=%0d a=%b b=%b want 7/%b", i, phase, led_a, led_b, fl[i]);
            end
        end
        n_cmp++; if (ack_cnt - a0 !== 0) begin n_bad++; $display("FAIL flash_ack got %0d pulses want 0", ack_cnt - a0); end
        night = 1'b0;
        tick_once();
        n_cmp++; if (phase !== 3'd2 || led_a !== 3'b101 || led_b !== 3'b101) begin
            n_bad++; $display("FAIL flash_exit got ph=%0d a=%b b=%b want 2/101/101", phase, led_a, led_b);
        end
        for (int i = 0; i < 5; i++) begin
            tick_once();
            n_cmp++; if (phase !== 3'd0) begin
                n_bad++; $display("FAIL flash_after[%0d] got ph=%0d want 0", i, phase);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_b_cycle();
        test_ped();
        test_both();
        test_reset_mid();
`ifdef NIGHT_FLASH_EN
        test_flash();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
